// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, sequencer state encoding and timeout default.
package alu_pkg;

    localparam logic [4:0] ALU_AND    = 5'b00000;
    localparam logic [4:0] ALU_OR     = 5'b00001;
    localparam logic [4:0] ALU_XOR    = 5'b00010;
    localparam logic [4:0] ALU_SLL    = 5'b00011;
    localparam logic [4:0] ALU_SRL    = 5'b00100;
    localparam logic [4:0] ALU_SRA    = 5'b00101;
    localparam logic [4:0] ALU_ADD    = 5'b00110;
    localparam logic [4:0] ALU_SUB    = 5'b00111;
    localparam logic [4:0] ALU_FP_MUL = 5'b01000;

    localparam int TIMEOUT_CYCLES_DEF = 1024;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_BEAT1,
        SEQ_BEAT2,
        SEQ_WAIT,
        SEQ_RESP
    } seq_state_t;

endpackage

// File: rtl/alu_seq_timeout.sv
// Loadable down-counter for the WAIT-state timeout; expired is high on the last allowed WAIT cycle.
module alu_seq_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= LOAD_VAL;
        else if (load)
            cnt <= LOAD_VAL;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expired = en && (cnt == '0);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ALU issue stage: one command per handshake, one- or two-beat start, bounded wait, registered response.
// Optional build macro ALU_SEQ_PERF_EN adds perf_cmd_count / perf_last_latency outputs.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int         WIDTH          = 32,
    parameter int         TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter logic [4:0] OP_FP_MUL      = ALU_FP_MUL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [4:0]       cmd_op,
    input  logic             cmd_fp,
    input  logic             cmd_rs1_signed,
    input  logic             cmd_rs2_signed,
    input  logic [WIDTH-1:0] cmd_a_int,
    input  logic [WIDTH-1:0] cmd_b_int,
    input  logic [WIDTH-1:0] cmd_a_frac,
    input  logic [WIDTH-1:0] cmd_b_frac,
    output logic             alu_start,
    output logic [4:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_fp,
    output logic             alu_rs1_signed,
    output logic             alu_rs2_signed,
    input  logic             alu_busy,
    input  logic             alu_valid,
    input  logic             alu_error,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_error,
    output logic             rsp_timeout
`ifdef ALU_SEQ_PERF_EN
    ,
    output logic [31:0]      perf_cmd_count,
    output logic [15:0]      perf_last_latency
`endif
);

    seq_state_t       state;
    logic             is_fp;
    logic             second_cyc;
    logic [WIDTH-1:0] a_frac_q;
    logic [WIDTH-1:0] b_frac_q;
    logic             tmo_expired;
    logic             accept;
    logic             alu_done;
    logic             resp_enter;

    assign accept     = (state == SEQ_IDLE) && cmd_valid && cmd_ready;
    assign alu_done   = alu_valid || alu_error;
    assign resp_enter = ((state == SEQ_BEAT2) && alu_done) ||
                        ((state == SEQ_WAIT) && (alu_done || tmo_expired));

    // Reloaded in every non-WAIT state so each WAIT entry starts a fresh count.
    alu_seq_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .load   (state != SEQ_WAIT),
        .en     (state == SEQ_WAIT),
        .expired(tmo_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= SEQ_IDLE;
            cmd_ready      <= 1'b1;
            alu_start      <= 1'b0;
            alu_op         <= '0;
            alu_a          <= '0;
            alu_b          <= '0;
            alu_fp         <= 1'b0;
            alu_rs1_signed <= 1'b0;
            alu_rs2_signed <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_error      <= 1'b0;
            rsp_timeout    <= 1'b0;
            is_fp          <= 1'b0;
            second_cyc     <= 1'b0;
            a_frac_q       <= '0;
            b_frac_q       <= '0;
        end else begin
            case (state)
                SEQ_IDLE: begin
                    cmd_ready <= !alu_busy;
                    if (accept) begin
                        cmd_ready      <= 1'b0;
                        alu_start      <= 1'b1;
                        alu_op         <= cmd_op;
                        alu_fp         <= cmd_fp;
                        alu_rs1_signed <= cmd_rs1_signed;
                        alu_rs2_signed <= cmd_rs2_signed;
                        alu_a          <= cmd_a_int;
                        alu_b          <= cmd_b_int;
                        a_frac_q       <= cmd_a_frac;
                        b_frac_q       <= cmd_b_frac;
                        is_fp          <= (cmd_op == OP_FP_MUL);
                        second_cyc     <= 1'b0;
                        state          <= SEQ_BEAT1;
                    end
                end
                SEQ_BEAT1: begin
                    if (!is_fp) begin
                        alu_start <= 1'b0;
                        state     <= SEQ_WAIT;
                    end else if (!second_cyc) begin
                        second_cyc <= 1'b1;
                    end else begin
                        alu_a <= a_frac_q;
                        alu_b <= b_frac_q;
                        state <= SEQ_BEAT2;
                    end
                end
                SEQ_BEAT2, SEQ_WAIT: begin
                    alu_start <= 1'b0;
                    if (resp_enter) begin
                        rsp_valid <= 1'b1;
                        // A real ALU response wins over a coincident timeout.
                        if (alu_done) begin
                            rsp_data    <= alu_result;
                            rsp_error   <= alu_error;
                            rsp_timeout <= 1'b0;
                        end else begin
                            rsp_data    <= '0;
                            rsp_error   <= 1'b0;
                            rsp_timeout <= 1'b1;
                        end
                        state <= SEQ_RESP;
                    end else begin
                        state <= SEQ_WAIT;
                    end
                end
                SEQ_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_error   <= 1'b0;
                        rsp_timeout <= 1'b0;
                        cmd_ready   <= !alu_busy;
                        state       <= SEQ_IDLE;
                    end
                end
                default: state <= SEQ_IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_PERF_EN
    logic [15:0] lat_cnt;

    // lat_cnt holds the number of edges since accept, so it equals the latency on the RESP-entry edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cmd_count    <= '0;
            perf_last_latency <= '0;
            lat_cnt           <= '0;
        end else begin
            if (accept) begin
                perf_cmd_count <= perf_cmd_count + 1'b1;
                lat_cnt        <= 16'd1;
            end else if (state != SEQ_IDLE && state != SEQ_RESP && lat_cnt != 16'hFFFF) begin
                lat_cnt <= lat_cnt + 1'b1;
            end
            if (resp_enter)
                perf_last_latency <= lat_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: stub ALU plus a spec-level reference model.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int W   = 32;
    localparam int TMO = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cmd_valid = 1'b0, cmd_ready;
    logic [4:0]   cmd_op = '0;
    logic         cmd_fp = 1'b0, cmd_rs1_signed = 1'b0, cmd_rs2_signed = 1'b0;
    logic [W-1:0] cmd_a_int = '0, cmd_b_int = '0, cmd_a_frac = '0, cmd_b_frac = '0;
    logic         alu_start, alu_fp, alu_rs1_signed, alu_rs2_signed;
    logic [4:0]   alu_op;
    logic [W-1:0] alu_a, alu_b;
    logic         alu_busy = 1'b0, alu_valid = 1'b0, alu_error = 1'b0;
    logic [W-1:0] alu_result = '0;
    logic         rsp_valid, rsp_ready = 1'b0, rsp_error, rsp_timeout;
    logic [W-1:0] rsp_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(TMO), .OP_FP_MUL(ALU_FP_MUL)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_fp(cmd_fp),
        .cmd_rs1_signed(cmd_rs1_signed), .cmd_rs2_signed(cmd_rs2_signed),
        .cmd_a_int(cmd_a_int), .cmd_b_int(cmd_b_int), .cmd_a_frac(cmd_a_frac), .cmd_b_frac(cmd_b_frac),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_fp(alu_fp),
        .alu_rs1_signed(alu_rs1_signed), .alu_rs2_signed(alu_rs2_signed),
        .alu_busy(alu_busy), .alu_valid(alu_valid), .alu_error(alu_error), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout)
    );

    // ALU behaviour; the FP product for the reference operand set is the known IEEE754 answer.
    function automatic logic [W-1:0] alu_fn(input logic [4:0] op, input logic [W-1:0] a, b, af, bf);
        case (op)
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_SLL: return a << b[4:0];
            ALU_SRL: return a >> b[4:0];
            ALU_SRA: return W'($signed(a) >>> b[4:0]);
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_FP_MUL:
                if (a == 32'h0000062C && af == 32'h0000004B && b == 32'h55650030 && bf == 32'h73101280)
                    return 32'h47EA3B9A;
                else
                    return (a * b) ^ (af + bf);
            default: return a ^ ~b;
        endcase
    endfunction

    // Stub ALU. mode 0: valid, 1: silent, 2: valid+error, 3: error only. Replies stub_lat cycles after start ends.
    int           stub_mode = 0;
    int           stub_lat  = 0;
    logic [W-1:0] sa [3];
    logic [W-1:0] sb [3];
    int           nb   = 0;
    int           wcnt = -1;
    logic [W-1:0] res_hold = '0;

    always @(posedge clk) begin
        alu_valid <= 1'b0;
        alu_error <= 1'b0;
        if (!rst) begin
            nb   <= 0;
            wcnt <= -1;
        end else if (alu_start) begin
            if (nb < 3) begin
                sa[nb] <= alu_a;
                sb[nb] <= alu_b;
            end
            nb   <= nb + 1;
            wcnt <= -1;
        end else if (nb != 0) begin
            res_hold <= (nb == 3) ? alu_fn(alu_op, sa[0], sb[0], sa[2], sb[2])
                                  : alu_fn(alu_op, sa[0], sb[0], '0, '0);
            nb   <= 0;
            wcnt <= stub_lat;
        end else if (wcnt == 0) begin
            if (stub_mode != 1) begin
                alu_valid  <= (stub_mode != 3);
                alu_error  <= (stub_mode >= 2);
                alu_result <= res_hold;
            end
            wcnt <= -1;
        end else if (wcnt > 0) begin
            wcnt <= wcnt - 1;
        end
    end

    // Reference model: what the response must be for a command given the ALU's behaviour.
    function automatic void model(input logic [4:0] op, input logic [W-1:0] ai, bi, af, bf,
                                  input int mode, input int lat,
                                  output logic [W-1:0] d, output logic e, output logic t,
                                  output int l, output int beats);
        bit fp = (op == ALU_FP_MUL);
        d     = (mode == 1) ? '0 : alu_fn(op, ai, bi, af, bf);
        e     = (mode >= 2);
        t     = (mode == 1);
        l     = (mode == 1) ? ((fp ? 3 : 1) + TMO) : ((fp ? 6 : 4) + lat);
        beats = fp ? 3 : 1;
    endfunction

    // Observations of the last transaction
    logic [W-1:0] obs_a[$], obs_b[$];
    logic [W-1:0] obs_data;
    logic         obs_err, obs_tmo, obs_done, obs_stable, obs_cr_low, obs_cr_after, obs_rv_after;
    logic         obs_ctrl_ok;
    int           obs_lat;

    task automatic do_cmd(input logic [4:0] op, input logic [W-1:0] ai, bi, af, bf, input int hold);
        int  budget;
        bit  first;
        obs_a.delete(); obs_b.delete();
        obs_done = 0; obs_stable = 1; obs_cr_low = 1; obs_ctrl_ok = 1; obs_lat = -1; first = 1;
        @(negedge clk);
        cmd_op = op; cmd_fp = (op == ALU_FP_MUL);
        cmd_rs1_signed = 1'($urandom_range(0, 1)); cmd_rs2_signed = 1'($urandom_range(0, 1));
        cmd_a_int = ai; cmd_b_int = bi; cmd_a_frac = af; cmd_b_frac = bf;
        cmd_valid = 1'b1;
        budget = 0;
        while (!cmd_ready && budget < 50) begin @(negedge clk); budget++; end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        budget = 0;
        while (budget < 300) begin
            obs_lat++;
            if (alu_start) begin
                obs_a.push_back(alu_a); obs_b.push_back(alu_b);
                if (first && (alu_op !== op || alu_fp !== cmd_fp ||
                              alu_rs1_signed !== cmd_rs1_signed || alu_rs2_signed !== cmd_rs2_signed))
                    obs_ctrl_ok = 0;
                first = 0;
            end
            if (rsp_valid) begin obs_done = 1; break; end
            if (cmd_ready) obs_cr_low = 0;
            @(negedge clk);
            budget++;
        end
        obs_data = rsp_data; obs_err = rsp_error; obs_tmo = rsp_timeout;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== obs_data || rsp_error !== obs_err || rsp_timeout !== obs_tmo)
                obs_stable = 0;
            if (cmd_ready) obs_cr_low = 0;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        obs_cr_after = cmd_ready;
        obs_rv_after = rsp_valid;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
        end
        n_checks++;
        if ({alu_start, rsp_valid, rsp_error, rsp_timeout, alu_fp} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 00000",
                               {alu_start, rsp_valid, rsp_error, rsp_timeout, alu_fp});
        end
        n_checks++;
        if ((alu_a | alu_b | rsp_data) !== '0 || alu_op !== 5'd0) begin
            n_fail++; $display("FAIL reset_data: got a=%h b=%h d=%h op=%h expected 0", alu_a, alu_b, rsp_data, alu_op);
        end
    endtask

    task automatic test_int_and;
        stub_mode = 0; stub_lat = 1;
        do_cmd(ALU_AND, 32'h0A010114, 32'h06020014, 32'h0, 32'h0, 0);
        n_checks++;
        if (!obs_done || obs_data !== 32'h02000014 || obs_err !== 1'b0) begin
            n_fail++; $display("FAIL and_result: got done=%b d=%h e=%b expected d=02000014 e=0", obs_done, obs_data, obs_err);
        end
        n_checks++;
        if (obs_a.size() != 1 || obs_a[0] !== 32'h0A010114 || obs_b[0] !== 32'h06020014) begin
            n_fail++; $display("FAIL and_start_pulse: got %0d beats expected 1", obs_a.size());
        end
        n_checks++;
        if (obs_lat != 5 || !obs_ctrl_ok) begin
            n_fail++; $display("FAIL and_latency: got %0d ctrl_ok=%b expected 5", obs_lat, obs_ctrl_ok);
        end
    endtask

    task automatic test_add_backpressure;
        stub_mode = 0; stub_lat = 2;
        do_cmd(ALU_ADD, 32'hA3B52F1D, 32'h7D3E9A0B, 32'h0, 32'h0, 20);
        n_checks++;
        if (!obs_done || obs_data !== 32'h20F3C928) begin
            n_fail++; $display("FAIL add_result: got done=%b d=%h expected 20F3C928", obs_done, obs_data);
        end
        n_checks++;
        if (!obs_stable || !obs_cr_low) begin
            n_fail++; $display("FAIL add_hold: got stable=%b cmd_ready_low=%b expected 1 1", obs_stable, obs_cr_low);
        end
        n_checks++;
        if (obs_cr_after !== 1'b1 || obs_rv_after !== 1'b0) begin
            n_fail++; $display("FAIL add_release: got cmd_ready=%b rsp_valid=%b expected 1 0", obs_cr_after, obs_rv_after);
        end
    endtask

    task automatic test_fp_mul;
        stub_mode = 0; stub_lat = 0;
        do_cmd(ALU_FP_MUL, 32'h0000062C, 32'h55650030, 32'h0000004B, 32'h73101280, 1);
        n_checks++;
        if (obs_a.size() != 3 || obs_a[0] !== 32'h0000062C || obs_a[1] !== 32'h0000062C || obs_a[2] !== 32'h0000004B ||
            obs_b[0] !== 32'h55650030 || obs_b[1] !== 32'h55650030 || obs_b[2] !== 32'h73101280) begin
            n_fail++; $display("FAIL fp_beats: got %0d beats expected int,int,frac", obs_a.size());
        end
        n_checks++;
        if (!obs_done || obs_data !== 32'h47EA3B9A || obs_err !== 1'b0) begin
            n_fail++; $display("FAIL fp_result: got d=%h e=%b expected 47EA3B9A 0", obs_data, obs_err);
        end
        n_checks++;
        if (obs_lat != 6 || !obs_ctrl_ok) begin
            n_fail++; $display("FAIL fp_latency: got %0d ctrl_ok=%b expected 6", obs_lat, obs_ctrl_ok);
        end
    endtask

    task automatic test_timeout;
        stub_mode = 1; stub_lat = 0;
        do_cmd(ALU_ADD, 32'h11111111, 32'h22222222, 32'h0, 32'h0, 2);
        n_checks++;
        if (!obs_done || obs_tmo !== 1'b1 || obs_data !== '0 || obs_err !== 1'b0) begin
            n_fail++; $display("FAIL timeout_rsp: got done=%b t=%b d=%h e=%b expected 1 1 0 0", obs_done, obs_tmo, obs_data, obs_err);
        end
        n_checks++;
        if (obs_lat != 1 + TMO) begin
            n_fail++; $display("FAIL timeout_latency: got %0d expected %0d", obs_lat, 1 + TMO);
        end
        stub_mode = 0;
    endtask

    task automatic test_error_reset;
        int budget;
        stub_mode = 2; stub_lat = 0;
        do_cmd(ALU_ADD, 32'h12345678, 32'h0, 32'h0, 32'h0, 0);
        n_checks++;
        if (!obs_done || obs_err !== 1'b1 || obs_data !== 32'h12345678 || obs_tmo !== 1'b0) begin
            n_fail++; $display("FAIL err_rsp: got e=%b d=%h t=%b expected 1 12345678 0", obs_err, obs_data, obs_tmo);
        end
        stub_mode = 0;
        @(negedge clk);
        cmd_op = ALU_FP_MUL; cmd_fp = 1'b1; cmd_a_int = 32'hDEAD0001; cmd_b_int = 32'hBEEF0002;
        cmd_valid = 1'b1;
        budget = 0;
        while (!cmd_ready && budget < 50) begin @(negedge clk); budget++; end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        n_checks++;
        if (alu_start !== 1'b1) begin
            n_fail++; $display("FAIL rst_issue: got alu_start=%b expected 1", alu_start);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (alu_start !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_midop: got start=%b rv=%b cr=%b expected 0 0 1", alu_start, rsp_valid, cmd_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (alu_start !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_release: got start=%b rv=%b cr=%b expected 0 0 1", alu_start, rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_busy_gating;
        int  budget;
        bit  quiet = 1;
        stub_mode = 0; stub_lat = 0;
        @(negedge clk);
        alu_busy = 1'b1;
        @(negedge clk);
        cmd_op = ALU_XOR; cmd_fp = 1'b0; cmd_a_int = 32'hF0F0F0F0; cmd_b_int = 32'h0FF00FF0;
        cmd_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (alu_start !== 1'b0 || cmd_ready !== 1'b0) quiet = 0;
        end
        n_checks++;
        if (!quiet) begin
            n_fail++; $display("FAIL busy_hold: got start/ready activity while busy expected none");
        end
        alu_busy = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || alu_start !== 1'b0) begin
            n_fail++; $display("FAIL busy_ready: got cr=%b start=%b expected 1 0", cmd_ready, alu_start);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++;
        if (alu_start !== 1'b1 || alu_a !== 32'hF0F0F0F0) begin
            n_fail++; $display("FAIL busy_issue: got start=%b a=%h expected 1 f0f0f0f0", alu_start, alu_a);
        end
        budget = 0;
        while (!rsp_valid && budget < 100) begin @(negedge clk); budget++; end
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hFF00FF00) begin
            n_fail++; $display("FAIL busy_result: got rv=%b d=%h expected 1 ff00ff00", rsp_valid, rsp_data);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_random;
        logic [4:0]   op;
        logic [W-1:0] ai, bi, af, bf, ed;
        logic         ee, et;
        int           el, eb, hold;
        bit           fp;
        for (int it = 0; it < 24; it++) begin
            op = 5'($urandom_range(0, 8));
            if (it % 4 == 3) op = ALU_FP_MUL;
            fp = (op == ALU_FP_MUL);
            ai = $urandom; bi = $urandom; af = $urandom; bf = $urandom;
            stub_mode = (it % 6 == 5) ? 1 : int'($urandom_range(0, 3) == 0 ? $urandom_range(2, 3) : 0);
            stub_lat  = int'($urandom_range(0, 5));
            hold      = int'($urandom_range(0, 3));
            model(op, ai, bi, af, bf, stub_mode, stub_lat, ed, ee, et, el, eb);
            do_cmd(op, ai, bi, af, bf, hold);
            n_checks++;
            if (!obs_done || obs_data !== ed || obs_err !== ee || obs_tmo !== et) begin
                n_fail++; $display("FAIL rand_rsp[%0d]: got d=%h e=%b t=%b expected d=%h e=%b t=%b",
                                   it, obs_data, obs_err, obs_tmo, ed, ee, et);
            end
            n_checks++;
            if (obs_lat != el || obs_a.size() != eb || obs_a[0] !== ai || obs_b[0] !== bi ||
                obs_a[eb-1] !== (fp ? af : ai) || obs_b[eb-1] !== (fp ? bf : bi) || !obs_ctrl_ok) begin
                n_fail++; $display("FAIL rand_issue[%0d]: got lat=%0d beats=%0d ctrl_ok=%b expected lat=%0d beats=%0d",
                                   it, obs_lat, obs_a.size(), obs_ctrl_ok, el, eb);
            end
            n_checks++;
            if (!obs_stable || !obs_cr_low || obs_cr_after !== 1'b1 || obs_rv_after !== 1'b0) begin
                n_fail++; $display("FAIL rand_handshake[%0d]: got stable=%b crlow=%b cr=%b rv=%b expected 1 1 1 0",
                                   it, obs_stable, obs_cr_low, obs_cr_after, obs_rv_after);
            end
        end
        stub_mode = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset;
        rst = 1'b1;
        @(negedge clk);
        test_int_and;
        test_add_backpressure;
        test_fp_mul;
        test_timeout;
        test_error_reset;
        test_busy_gating;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
